// File: rtl/gf_mat_vec_mul_acc.sv
// GF(2^8) matrix-vector multiplier with optional accumulate into an internal result array.
// M and x stream from external one-cycle-latency memories, with one word per cycle and no stalls.
module gf_mat_vec_mul_acc #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8,
  parameter int unsigned N_GF = 2,
  parameter logic [7:0]  POLY = 8'h1B,
  localparam int unsigned W   = 8 * N_GF,
  localparam int unsigned WPR = COLS / N_GF,
  localparam int unsigned NW  = ROWS * WPR,
  localparam int unsigned MAW = (NW > 1) ? $clog2(NW) : 1,
  localparam int unsigned VAW = (WPR > 1) ? $clog2(WPR) : 1,
  localparam int unsigned RAW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_acc,
  input  logic           i_clear,
  output logic [MAW-1:0] o_mat_addr,
  output logic [VAW-1:0] o_vec_addr,
  input  logic [W-1:0]   i_mat,
  input  logic [W-1:0]   i_vec,
  input  logic [RAW-1:0] i_res_addr,
  output logic [7:0]     o_res,
  output logic           o_busy,
  output logic           o_done,
  output logic [1:0]     o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

  state_t         state_q;
  logic [MAW-1:0] mat_addr_q;
  logic [VAW-1:0] vec_addr_q;
  logic [RAW-1:0] row_q;
  logic           acc_mode_q;
  logic           busy_q;
  logic           done_q;
  logic [7:0]     res_out_q;
  logic [7:0]     res_q [ROWS];

  // Tag travelling with the word whose data arrives one cycle after its address.
  logic           tag_vld_q;
  logic           tag_first_q;
  logic           tag_last_q;
  logic [RAW-1:0] tag_row_q;
  logic [7:0]     acc_q;

  logic [7:0]     prod_d;
  logic [7:0]     acc_d;
  logic [7:0]     wr_d;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? POLY : 8'h00);
    end
    return r;
  endfunction

  always_comb begin
    prod_d = 8'h00;
    for (int j = 0; j < int'(N_GF); j++) begin
      prod_d = prod_d ^ gf_mul(i_mat[W-1-8*j -: 8], i_vec[W-1-8*j -: 8]);
    end
    acc_d = (tag_first_q ? 8'h00 : acc_q) ^ prod_d;
    wr_d  = acc_d ^ (acc_mode_q ? res_q[tag_row_q] : 8'h00);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      mat_addr_q  <= '0;
      vec_addr_q  <= '0;
      row_q       <= '0;
      acc_mode_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_out_q   <= 8'h00;
      tag_vld_q   <= 1'b0;
      tag_first_q <= 1'b0;
      tag_last_q  <= 1'b0;
      tag_row_q   <= '0;
      acc_q       <= 8'h00;
      for (int r = 0; r < int'(ROWS); r++) res_q[r] <= 8'h00;
    end else begin
      done_q    <= 1'b0;
      tag_vld_q <= 1'b0;
      res_out_q <= (32'(i_res_addr) < ROWS) ? res_q[i_res_addr] : 8'h00;

      if (tag_vld_q) begin
        acc_q <= acc_d;
        if (tag_last_q) res_q[tag_row_q] <= wr_d;
      end

      case (state_q)
        S_IDLE: begin
          if (i_clear) begin
            for (int r = 0; r < int'(ROWS); r++) res_q[r] <= 8'h00;
          end
          if (i_start) begin
            state_q    <= S_ISSUE;
            acc_mode_q <= i_acc;
            mat_addr_q <= '0;
            vec_addr_q <= '0;
            row_q      <= '0;
            busy_q     <= 1'b1;
          end
        end
        S_ISSUE: begin
          tag_vld_q   <= 1'b1;
          tag_row_q   <= row_q;
          tag_first_q <= (vec_addr_q == '0);
          tag_last_q  <= (vec_addr_q == VAW'(WPR - 1));
          // Addresses hold at the final word so they never wrap past NW-1.
          if (mat_addr_q == MAW'(NW - 1)) begin
            state_q <= S_DRAIN;
          end else begin
            mat_addr_q <= mat_addr_q + MAW'(1);
            if (vec_addr_q == VAW'(WPR - 1)) begin
              vec_addr_q <= '0;
              row_q      <= row_q + RAW'(1);
            end else begin
              vec_addr_q <= vec_addr_q + VAW'(1);
            end
          end
        end
        S_DRAIN: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_mat_addr  = mat_addr_q;
  assign o_vec_addr  = vec_addr_q;
  assign o_res       = res_out_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_gf_mat_vec_mul_acc.sv
// Directed bench for gf_mat_vec_mul_acc: an 8x8/2-lane instance and a 5x6/3-lane instance
// fed from behavioural one-cycle-latency memories.
module tb_gf_mat_vec_mul_acc;
  localparam int AR = 8, AC = 8, AN = 2, AW = 16, AWPR = 4, ANW = 32;
  localparam int BR = 5, BC = 6, BN = 3, BW = 24, BWPR = 2, BNW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  logic          a_start, a_acc, a_clear;
  logic [4:0]    a_mat_addr;
  logic [1:0]    a_vec_addr;
  logic [AW-1:0] a_mat, a_vec;
  logic [2:0]    a_res_addr;
  logic [7:0]    a_res;
  logic          a_busy, a_done;
  logic [1:0]    a_state;
  logic [7:0]    ma [AR][AC];
  logic [7:0]    xa [AC];

  logic          b_start, b_acc, b_clear;
  logic [3:0]    b_mat_addr;
  logic [0:0]    b_vec_addr;
  logic [BW-1:0] b_mat, b_vec;
  logic [2:0]    b_res_addr;
  logic [7:0]    b_res;
  logic          b_busy, b_done;
  logic [1:0]    b_state;
  logic [7:0]    mb [BR][BC];
  logic [7:0]    xb [BC];
  logic [7:0]    b_ref [BR];

  gf_mat_vec_mul_acc #(.ROWS(AR), .COLS(AC), .N_GF(AN), .POLY(8'h1B)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_acc(a_acc), .i_clear(a_clear),
    .o_mat_addr(a_mat_addr), .o_vec_addr(a_vec_addr), .i_mat(a_mat), .i_vec(a_vec),
    .i_res_addr(a_res_addr), .o_res(a_res), .o_busy(a_busy), .o_done(a_done),
    .o_dbg_state(a_state)
  );

  gf_mat_vec_mul_acc #(.ROWS(BR), .COLS(BC), .N_GF(BN), .POLY(8'h1B)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_acc(b_acc), .i_clear(b_clear),
    .o_mat_addr(b_mat_addr), .o_vec_addr(b_vec_addr), .i_mat(b_mat), .i_vec(b_vec),
    .i_res_addr(b_res_addr), .o_res(b_res), .o_busy(b_busy), .o_done(b_done),
    .o_dbg_state(b_state)
  );

  // Memory models: word k of row r holds columns w*N..w*N+N-1, lane 0 in the top byte.
  always @(posedge clk) begin
    for (int j = 0; j < AN; j++) begin
      a_mat[AW-1-8*j -: 8] <= ma[int'(a_mat_addr) / AWPR][(int'(a_mat_addr) % AWPR) * AN + j];
      a_vec[AW-1-8*j -: 8] <= xa[int'(a_vec_addr) * AN + j];
    end
    for (int j = 0; j < BN; j++) begin
      b_mat[BW-1-8*j -: 8] <= mb[int'(b_mat_addr) / BWPR][(int'(b_mat_addr) % BWPR) * BN + j];
      b_vec[BW-1-8*j -: 8] <= xb[int'(b_vec_addr) * BN + j];
    end
  end

  // Reference multiply: carry-less product, then reduce by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11B << (i - 8));
    return p[7:0];
  endfunction

  task automatic read_a(input int addr, output logic [7:0] v);
    a_res_addr = 3'(addr);
    @(posedge clk); @(negedge clk);
    v = a_res;
  endtask

  task automatic read_b(input int addr, output logic [7:0] v);
    b_res_addr = 3'(addr);
    @(posedge clk); @(negedge clk);
    v = b_res;
  endtask

  // Called at a negedge; cyc = cycles from the start cycle to the o_done cycle, -1 on timeout.
  task automatic run_a(input logic acc, output int cyc, output logic busy1);
    a_acc = acc; a_start = 1'b1; cyc = -1; busy1 = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 1) begin a_start = 1'b0; busy1 = a_busy; end
      if (a_done) begin cyc = n; break; end
    end
    a_start = 1'b0;
  endtask

  task automatic run_b(input logic acc, output int cyc);
    b_acc = acc; b_start = 1'b1; cyc = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 1) b_start = 1'b0;
      if (b_done) begin cyc = n; break; end
    end
    b_start = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", a_busy); end
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %0b want 0", a_done); end
    total++; if (a_mat_addr !== 5'd0) begin bad++; $display("FAIL rst_mat_addr: got %0d want 0", a_mat_addr); end
    total++; if (a_vec_addr !== 2'd0) begin bad++; $display("FAIL rst_vec_addr: got %0d want 0", a_vec_addr); end
    total++; if (a_res !== 8'h00) begin bad++; $display("FAIL rst_res: got %0h want 00", a_res); end
    total++; if (a_state !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", a_state); end
    total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL rst_b_busy: got %0b want 0", b_busy); end
  endtask

  task automatic test_gf_arith();
    int cyc; logic b1; logic [7:0] v, e;
    for (int r = 0; r < AR; r++) for (int c = 0; c < AC; c++) ma[r][c] = 8'h00;
    for (int c = 0; c < AC; c++) xa[c] = 8'h00;
    ma[0][0] = 8'h57; ma[0][1] = 8'h02; xa[0] = 8'h83; xa[1] = 8'h80;
    run_a(1'b0, cyc, b1);
    total++; if (b1 !== 1'b1) begin bad++; $display("FAIL arith_busy: got %0b want 1", b1); end
    total++; if (cyc !== ANW + 2) begin bad++; $display("FAIL arith_latency: got %0d want %0d", cyc, ANW + 2); end
    exp_q.push_back(8'hDA);
    for (int r = 1; r < AR; r++) exp_q.push_back(8'h00);
    for (int r = 0; r < AR; r++) begin
      read_a(r, v); e = exp_q.pop_front();
      total++; if (v !== e) begin bad++; $display("FAIL arith_res[%0d]: got %0h want %0h", r, v, e); end
    end
  endtask

  task automatic test_identity();
    int cyc; logic b1; logic [7:0] v, e;
    for (int r = 0; r < AR; r++) for (int c = 0; c < AC; c++) ma[r][c] = (r == c) ? 8'h01 : 8'h00;
    for (int c = 0; c < AC; c++) xa[c] = 8'(c + 1);
    for (int pass = 0; pass < 3; pass++) begin
      run_a(pass == 1, cyc, b1);
      total++; if (cyc !== ANW + 2) begin bad++; $display("FAIL id_latency[%0d]: got %0d want %0d", pass, cyc, ANW + 2); end
      for (int r = 0; r < AR; r++) exp_q.push_back((pass == 1) ? 8'h00 : 8'(r + 1));
      for (int r = 0; r < AR; r++) begin
        read_a(r, v); e = exp_q.pop_front();
        total++; if (v !== e) begin bad++; $display("FAIL id_res[%0d][%0d]: got %0h want %0h", pass, r, v, e); end
      end
    end
  endtask

  task automatic test_clear_back_to_back();
    int cyc; logic b1; logic [7:0] v, e;
    for (int r = 0; r < AR; r++) for (int c = 0; c < AC; c++) ma[r][c] = 8'h01;
    for (int c = 0; c < AC; c++) xa[c] = 8'(c + 1);
    a_clear = 1'b1; @(posedge clk); @(negedge clk); a_clear = 1'b0;
    read_a(3, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL clr_res3: got %0h want 00", v); end
    run_a(1'b1, cyc, b1);
    for (int r = 0; r < AR; r++) exp_q.push_back(8'h08);
    for (int r = 0; r < AR; r++) begin
      read_a(r, v); e = exp_q.pop_front();
      total++; if (v !== e) begin bad++; $display("FAIL clr_acc_res[%0d]: got %0h want %0h", r, v, e); end
    end
    run_a(1'b1, cyc, b1);
    @(posedge clk); @(negedge clk);
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy: got %0b want 0", a_busy); end
    run_a(1'b1, cyc, b1);
    total++; if (b1 !== 1'b1) begin bad++; $display("FAIL b2b_accept: got %0b want 1", b1); end
    total++; if (cyc !== ANW + 2) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", cyc, ANW + 2); end
    for (int r = 0; r < AR; r++) exp_q.push_back(8'h08);
    for (int r = 0; r < AR; r++) begin
      read_a(r, v); e = exp_q.pop_front();
      total++; if (v !== e) begin bad++; $display("FAIL b2b_res[%0d]: got %0h want %0h", r, v, e); end
    end
  endtask

  task automatic test_busy_ignore();
    int last, cnt; logic [7:0] v, e;
    for (int r = 0; r < AR; r++) for (int c = 0; c < AC; c++) ma[r][c] = (r == c) ? 8'h01 : 8'h00;
    for (int c = 0; c < AC; c++) xa[c] = 8'(c + 1);
    last = 0; cnt = 0;
    a_acc = 1'b0; a_start = 1'b1;
    for (int n = 1; n <= 3 * (ANW + 3); n++) begin
      @(posedge clk); @(negedge clk);
      if (a_done) begin
        cnt++;
        if (last > 0) begin
          total++; if (n - last !== ANW + 3) begin bad++; $display("FAIL busy_period: got %0d want %0d", n - last, ANW + 3); end
        end
        total++; if (a_mat_addr !== 5'(ANW - 1)) begin bad++; $display("FAIL busy_addr_done: got %0d want %0d", a_mat_addr, ANW - 1); end
        last = n;
      end else if (last > 0 && n == last + 1) begin
        total++; if (a_mat_addr !== 5'(ANW - 1)) begin bad++; $display("FAIL busy_addr_hold: got %0d want %0d", a_mat_addr, ANW - 1); end
      end else if (last > 0 && n == last + 2) begin
        total++; if (a_mat_addr !== 5'd0) begin bad++; $display("FAIL busy_addr_restart: got %0d want 0", a_mat_addr); end
      end
    end
    a_start = 1'b0;
    total++; if (cnt !== 3) begin bad++; $display("FAIL busy_done_count: got %0d want 3", cnt); end
    @(posedge clk); @(negedge clk);
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL busy_release: got %0b want 0", a_busy); end
    for (int r = 0; r < AR; r++) exp_q.push_back(8'(r + 1));
    for (int r = 0; r < AR; r++) begin
      read_a(r, v); e = exp_q.pop_front();
      total++; if (v !== e) begin bad++; $display("FAIL busy_res[%0d]: got %0h want %0h", r, v, e); end
    end
  endtask

  task automatic test_mid_reset();
    int cyc; logic b1; logic [7:0] v, e;
    a_acc = 1'b0; a_start = 1'b1;
    @(posedge clk); @(negedge clk); a_start = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL mrst_busy: got %0b want 0", a_busy); end
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL mrst_done: got %0b want 0", a_done); end
    total++; if (a_mat_addr !== 5'd0) begin bad++; $display("FAIL mrst_mat_addr: got %0d want 0", a_mat_addr); end
    total++; if (a_vec_addr !== 2'd0) begin bad++; $display("FAIL mrst_vec_addr: got %0d want 0", a_vec_addr); end
    total++; if (a_state !== 2'd0) begin bad++; $display("FAIL mrst_state: got %0d want 0", a_state); end
    rst = 1'b0;
    for (int r = 0; r < AR; r++) begin
      read_a(r, v);
      total++; if (v !== 8'h00) begin bad++; $display("FAIL mrst_res[%0d]: got %0h want 00", r, v); end
    end
    for (int r = 0; r < AR; r++) for (int c = 0; c < AC; c++) ma[r][c] = 8'(r * 19 + c * 7 + 1);
    for (int c = 0; c < AC; c++) xa[c] = 8'(8 - c);
    for (int r = 0; r < AR; r++) begin
      e = 8'h00;
      for (int c = 0; c < AC; c++) e = e ^ gf_ref(ma[r][c], xa[c]);
      exp_q.push_back(e);
    end
    run_a(1'b0, cyc, b1);
    total++; if (cyc !== ANW + 2) begin bad++; $display("FAIL mrst_latency: got %0d want %0d", cyc, ANW + 2); end
    for (int r = 0; r < AR; r++) begin
      read_a(r, v); e = exp_q.pop_front();
      total++; if (v !== e) begin bad++; $display("FAIL mrst_golden[%0d]: got %0h want %0h", r, v, e); end
    end
  endtask

  task automatic test_odd_shape();
    int cyc; logic [7:0] v, e;
    for (int r = 0; r < BR; r++) b_ref[r] = 8'h00;
    for (int pass = 0; pass < 3; pass++) begin
      for (int r = 0; r < BR; r++) for (int c = 0; c < BC; c++) mb[r][c] = 8'(r * 37 + c * 11 + 5 + pass * 101);
      for (int c = 0; c < BC; c++) xb[c] = 8'(c * 29 + 3 + pass * 53);
      for (int r = 0; r < BR; r++) begin
        e = 8'h00;
        for (int c = 0; c < BC; c++) e = e ^ gf_ref(mb[r][c], xb[c]);
        b_ref[r] = (pass == 1) ? (b_ref[r] ^ e) : e;
      end
      run_b(pass == 1, cyc);
      total++; if (cyc !== BNW + 2) begin bad++; $display("FAIL odd_latency[%0d]: got %0d want %0d", pass, cyc, BNW + 2); end
      for (int r = 0; r < BR; r++) exp_q.push_back(b_ref[r]);
      for (int r = BR; r < 8; r++) exp_q.push_back(8'h00);
      for (int r = 0; r < 8; r++) begin
        read_b(r, v); e = exp_q.pop_front();
        total++; if (v !== e) begin bad++; $display("FAIL odd_res[%0d][%0d]: got %0h want %0h", pass, r, v, e); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_acc = 1'b0; a_clear = 1'b0; a_res_addr = '0;
    b_start = 1'b0; b_acc = 1'b0; b_clear = 1'b0; b_res_addr = '0;
    for (int r = 0; r < AR; r++) for (int c = 0; c < AC; c++) ma[r][c] = 8'h00;
    for (int c = 0; c < AC; c++) xa[c] = 8'h00;
    for (int r = 0; r < BR; r++) for (int c = 0; c < BC; c++) mb[r][c] = 8'h00;
    for (int c = 0; c < BC; c++) xb[c] = 8'h00;
    @(negedge clk); @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_gf_arith();
    test_identity();
    test_clear_back_to_back();
    test_busy_ignore();
    test_mid_reset();
    test_odd_shape();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
